// File: rtl/imem_loader_if.sv
// Loader bus: program byte handshake in, ROM write strobe, fetch gating and session status out.
// Latency: none (wires only).
// Backpressure: byte_valid/byte_ready handshake; a byte moves when both are high at a rising edge.
interface imem_loader_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic            byte_valid;
   logic [7:0]      byte_data;
   logic            byte_ready;
   logic            fetch_ren;
   logic            imem_ren;
   logic            prog_en;
   logic [XLEN-1:0] prog_addr;
   logic [XLEN-1:0] prog_data;
   logic            core_hold;
   logic            busy;
   logic            done;
   logic            error;
   logic [XLEN-1:0] words_loaded;

   modport master (
      output start, byte_valid, byte_data, fetch_ren,
      input  byte_ready, imem_ren, prog_en, prog_addr, prog_data,
             core_hold, busy, done, error, words_loaded
   );

   modport slave (
      input  start, byte_valid, byte_data, fetch_ren,
      output byte_ready, imem_ren, prog_en, prog_addr, prog_data,
             core_hold, busy, done, error, words_loaded
   );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction ROM while holding fetch.
// Latency: ROM write one cycle after each word's 4th byte; done coincides with the final write.
// Backpressure: byte_ready high in LEN/DATA/CSUM only; trailing checksum under IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int ROM_SIZE = 8192,
   parameter int XLEN     = 32
) (
   input logic          clk,
   input logic          reset,
   imem_loader_if.slave bus
);
   localparam logic [XLEN-1:0] MAX_WORDS = XLEN'(ROM_SIZE / 4);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEN  = 3'd1,
      S_DATA = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM = 3'd3,
`endif
      S_FIN  = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   state_t          state_q;
   logic [1:0]      bcnt_q;
   logic [23:0]     asm_q;
   logic [XLEN-1:0] len_q;
   logic [XLEN-1:0] words_q;
   logic [XLEN-1:0] prog_addr_q;
   logic [XLEN-1:0] prog_data_q;
   logic            prog_en_q;
   logic            core_hold_q;
   logic            busy_q;
   logic            ready_q;
   logic            done_q;
   logic            error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0]     csum_q;
`endif

   logic            take_d;
   logic            start_ok_d;
   logic            last_d;
   logic [31:0]     word_d;
   logic [XLEN-1:0] word_x_d;

   // The 4th byte is used straight off the bus, so only three bytes need storing.
   assign word_d     = {bus.byte_data, asm_q};
   assign word_x_d   = XLEN'(word_d);
   assign take_d     = bus.byte_valid & ready_q;
   assign start_ok_d = bus.start & ((state_q == S_IDLE) || (state_q == S_FIN) || (state_q == S_ERR));
   assign last_d     = (words_q + XLEN'(1)) == len_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         bcnt_q      <= 2'd0;
         asm_q       <= 24'd0;
         len_q       <= '0;
         words_q     <= '0;
         prog_addr_q <= '0;
         prog_data_q <= '0;
         prog_en_q   <= 1'b0;
         core_hold_q <= 1'b0;
         busy_q      <= 1'b0;
         ready_q     <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q      <= 32'd0;
`endif
      end else begin
         prog_en_q <= 1'b0;
         done_q    <= 1'b0;
         if (start_ok_d) begin
            state_q     <= S_LEN;
            bcnt_q      <= 2'd0;
            asm_q       <= 24'd0;
            words_q     <= '0;
            error_q     <= 1'b0;
            core_hold_q <= 1'b1;
            busy_q      <= 1'b1;
            ready_q     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= 32'd0;
`endif
         end else if (take_d) begin
            bcnt_q <= bcnt_q + 2'd1;
            case (bcnt_q)
               2'd0: asm_q[7:0]   <= bus.byte_data;
               2'd1: asm_q[15:8]  <= bus.byte_data;
               2'd2: asm_q[23:16] <= bus.byte_data;
               default: begin
                  case (state_q)
                     S_LEN: begin
                        if ((word_x_d == '0) || (word_x_d > MAX_WORDS)) begin
                           state_q <= S_ERR;
                           error_q <= 1'b1;
                           busy_q  <= 1'b0;
                           ready_q <= 1'b0;
                        end else begin
                           len_q   <= word_x_d;
                           state_q <= S_DATA;
                        end
                     end
                     S_DATA: begin
                        prog_en_q   <= 1'b1;
                        prog_addr_q <= words_q << 2;
                        prog_data_q <= word_x_d;
                        words_q     <= words_q + XLEN'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q      <= csum_q + word_d;
                        if (last_d) state_q <= S_CSUM;
`else
                        if (last_d) begin
                           state_q     <= S_FIN;
                           done_q      <= 1'b1;
                           core_hold_q <= 1'b0;
                           busy_q      <= 1'b0;
                           ready_q     <= 1'b0;
                        end
`endif
                     end
`ifdef IMEM_LOADER_CHECKSUM_EN
                     S_CSUM: begin
                        busy_q  <= 1'b0;
                        ready_q <= 1'b0;
                        if (word_d == csum_q) begin
                           state_q     <= S_FIN;
                           done_q      <= 1'b1;
                           core_hold_q <= 1'b0;
                        end else begin
                           state_q <= S_ERR;
                           error_q <= 1'b1;
                        end
                     end
`endif
                     default: ;
                  endcase
               end
            endcase
         end
      end
   end

   assign bus.byte_ready   = ready_q;
   assign bus.imem_ren     = bus.fetch_ren & ~core_hold_q;
   assign bus.prog_en      = prog_en_q;
   assign bus.prog_addr    = prog_addr_q;
   assign bus.prog_data    = prog_data_q;
   assign bus.core_hold    = core_hold_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.error        = error_q;
   assign bus.words_loaded = words_q;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: expected ROM writes queued at stimulus time, popped by a monitor.
`timescale 1ns/1ps
module tb_imem_loader;
   localparam int XLEN     = 32;
   localparam int ROM_SIZE = 8192;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   imem_loader_if #(.XLEN(XLEN)) bus ();
   imem_loader #(.ROM_SIZE(ROM_SIZE), .XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
   wr_t         exp_q[$];
   int          total = 0;
   int          bad = 0;
   int          done_cnt = 0;
   bit          hold_exp = 1'b0;
   bit          rand_fetch = 1'b0;
   logic [31:0] last_addr = 32'd0;
   logic [31:0] last_data = 32'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      hold_exp = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_max);
      int guard = 0;
      bus.byte_valid = 1'b0;
      repeat ($urandom_range(0, gap_max)) tick();
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      while (!bus.byte_ready && guard < 64) begin
         tick();
         guard++;
      end
      if (guard >= 64) begin
         total++;
         bad++;
         $display("FAIL byte_ready timeout: ready=0 want 1");
      end
      tick();
      bus.byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap_max);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap_max);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " ctrl"}, {bus.core_hold, bus.busy, bus.done, bus.error, bus.prog_en, bus.byte_ready}, 0);
      check({tag, " prog_addr"}, bus.prog_addr, 0);
      check({tag, " prog_data"}, bus.prog_data, 0);
      check({tag, " words_loaded"}, bus.words_loaded, 0);
   endtask

   // Reference: word k of the program lands at byte address 4*k; done only if the stream is accepted.
   task automatic run_session(input logic [31:0] prog[$], input int gap_max, input bit midstart, input bit bad_sum);
      int          n = prog.size();
      int          d0 = done_cnt;
      int          mid = midstart ? 4 * (n / 2) + 1 : -1;
      logic [31:0] sum = 32'd0;
      bit          ok;
      pulse_start();
      send_word(n, gap_max);
      for (int k = 0; k < n; k++) begin
         exp_q.push_back('{addr: 32'(4 * k), data: prog[k]});
         sum += prog[k];
      end
      for (int i = 0; i < 4 * n; i++) begin
         if (i == mid) pulse_start();
         send_byte(prog[i / 4][8 * (i % 4) +: 8], gap_max);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(bad_sum ? sum + 32'd1 : sum, gap_max);
`endif
      ok = !bad_sum;
      repeat (3) tick();
      check("done pulses", done_cnt - d0, ok ? 1 : 0);
      check("words_loaded end", bus.words_loaded, n);
      check("error end", bus.error, !ok);
      check("core_hold end", bus.core_hold, !ok);
      check("busy end", bus.busy, 0);
      check("pending writes", exp_q.size(), 0);
   endtask

   task automatic run_bad_len(input logic [31:0] len);
      int d0 = done_cnt;
      pulse_start();
      send_word(len, 0);
      repeat (3) tick();
      check("badlen error", bus.error, 1);
      check("badlen core_hold", bus.core_hold, 1);
      check("badlen busy", bus.busy, 0);
      check("badlen byte_ready", bus.byte_ready, 0);
      check("badlen words_loaded", bus.words_loaded, 0);
      check("badlen done", done_cnt - d0, 0);
   endtask

   // Monitor: pops expected writes, tracks done and checks fetch gating every cycle.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            hold_exp  = 1'b0;
            last_addr = 32'd0;
            last_data = 32'd0;
         end else begin
            if (bus.done) begin
               done_cnt++;
               hold_exp = 1'b0;
            end
            check("imem_ren", bus.imem_ren, bus.fetch_ren & ~hold_exp);
            if (bus.prog_en) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected prog_en: addr=%0h data=%0h", bus.prog_addr, bus.prog_data);
               end else begin
                  e = exp_q.pop_front();
                  check("prog_addr", bus.prog_addr, e.addr);
                  check("prog_data", bus.prog_data, e.data);
                  check("words_loaded at write", bus.words_loaded, e.addr / 4 + 1);
                  last_addr = e.addr;
                  last_data = e.data;
               end
            end else begin
               check("prog_addr hold", bus.prog_addr, last_addr);
               check("prog_data hold", bus.prog_data, last_data);
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_fetch) bus.fetch_ren = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] p[$];
      reset          = 1'b1;
      bus.start      = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      bus.fetch_ren  = 1'b1;
      repeat (3) tick();
      check_reset_outputs("reset");
      reset = 1'b0;
      tick();

      p = '{32'h2021000A, 32'h20420005};
      run_session(p, 0, 1'b0, 1'b0);
      check("prog_addr after directed", bus.prog_addr, 32'h4);
      run_bad_len(32'h0000_0000);
      run_bad_len(32'h0000_0801);
`ifdef IMEM_LOADER_CHECKSUM_EN
      run_session(p, 0, 1'b0, 1'b1);
`endif

      // Reset five bytes into the data phase, then reload cleanly.
      pulse_start();
      send_word(32'd2, 0);
      exp_q.push_back('{addr: 32'h0, data: 32'h1122_3344});
      send_word(32'h1122_3344, 0);
      send_byte(8'h55, 0);
      reset = 1'b1;
      #1;
      check_reset_outputs("mid reset");
      check("mid reset pending", exp_q.size(), 0);
      tick();
      reset = 1'b0;
      tick();
      p = '{32'hCAFE_0001, 32'hBEEF_0002, 32'h0BAD_F00D};
      run_session(p, 0, 1'b0, 1'b0);

      // Largest legal length is accepted.
      pulse_start();
      send_word(32'(ROM_SIZE / 4), 0);
      tick();
      check("max len busy", bus.busy, 1);
      check("max len error", bus.error, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();

      for (int s = 0; s < 6; s++) begin
         int n = $urandom_range(1, 6);
         p = {};
         for (int k = 0; k < n; k++) p.push_back($urandom);
         rand_fetch = (s >= 2);
         run_session(p, 7, n >= 2, 1'b0);
      end
      rand_fetch    = 1'b0;
      bus.fetch_ren = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      p = '{$urandom, $urandom, $urandom};
      run_session(p, 3, 1'b1, 1'b1);
`endif
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
